pwm_capture: RTL and testbench

// - Receive-side counterpart of the team's PWM generator: measures an incoming PWM/servo

---
 rtl/pwm_capture.sv | 145 ++++++++++++++
 tb/tb_pwm_capture.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// PWM / servo waveform capture: measures high time and period in prescaler ticks and flags a stuck line.
// Define GLITCH_FILTER_EN to add a 3-sample unanimous filter after the synchronizer.
module pwm_capture #(
  parameter int unsigned DVSR_FAST = 10416,
  parameter int unsigned DVSR_SLOW = 200000,
  parameter int unsigned PRESC_W   = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pwm_in,
  input  logic       sel,
  output logic [6:0] duty_out,
  output logic [7:0] period_out,
  output logic       valid,
  output logic       stuck_hi,
  output logic       stuck_lo
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, STUCK} state_t;

  state_t             state;
  logic               sync1, sync2, line_q;
  logic               line_now, rise, fall;
  logic [PRESC_W-1:0] q, dvsr;
  logic               tick;
  logic [7:0]         hi_cnt, lo_cnt, hi_inc, lo_inc, lo_fin;
  logic [8:0]         sum;

`ifdef GLITCH_FILTER_EN
  logic hist1, hist2;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      hist1 <= 1'b0;
      hist2 <= 1'b0;
    end else begin
      hist1 <= sync2;
      hist2 <= hist1;
    end
  end

  // The filtered level follows the input only once three synchronized samples agree;
  // otherwise it holds the last accepted level kept in the edge register.
  assign line_now = (sync2 == hist1 && hist1 == hist2) ? sync2 : line_q;
`else
  assign line_now = sync2;
`endif

  assign rise = line_now & ~line_q;
  assign fall = ~line_now & line_q;

  // sel is used live; >= lets q recover at once when switching to a smaller divisor.
  assign dvsr = sel ? PRESC_W'(DVSR_SLOW) : PRESC_W'(DVSR_FAST);
  assign tick = (q >= dvsr);

  // NOTE: every variable written in an always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    hi_inc = (hi_cnt == 8'd255) ? 8'd255 : hi_cnt + 8'd1;
    lo_inc = (lo_cnt == 8'd255) ? 8'd255 : lo_cnt + 8'd1;
    // A tick coinciding with the closing rise belongs to the period that just ended.
    lo_fin = tick ? lo_inc : lo_cnt;
    sum    = {1'b0, hi_cnt} + {1'b0, lo_fin};
  end

  // NOTE: reset is asynchronous and asserted high on rst_n; all state is cleared in the reset branch.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      line_q <= 1'b0;
      q      <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      sync1  <= pwm_in;
      sync2  <= sync1;
      line_q <= line_now;
      if (rise || tick) q <= '0;
      else              q <= q + PRESC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state      <= IDLE;
      hi_cnt     <= 8'd0;
      lo_cnt     <= 8'd0;
      duty_out   <= 7'd0;
      period_out <= 8'd0;
      valid      <= 1'b0;
      stuck_hi   <= 1'b0;
      stuck_lo   <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (rise) begin
        hi_cnt <= 8'd0;
        lo_cnt <= 8'd0;
      end
      case (state)
        IDLE: begin
          if (rise) state <= HIGH;
        end
        HIGH: begin
          if (tick) hi_cnt <= hi_inc;
          if (fall) begin
            state <= LOW;
          end else if (tick && hi_inc == 8'd255) begin
            state      <= STUCK;
            duty_out   <= 7'd127;
            period_out <= 8'd255;
            stuck_hi   <= 1'b1;
            stuck_lo   <= 1'b0;
            valid      <= 1'b1;
          end
        end
        LOW: begin
          if (rise) begin
            state      <= HIGH;
            duty_out   <= (hi_cnt > 8'd127) ? 7'd127 : hi_cnt[6:0];
            period_out <= sum[8] ? 8'd255 : sum[7:0];
            valid      <= 1'b1;
          end else if (tick) begin
            lo_cnt <= lo_inc;
            if (lo_inc == 8'd255) begin
              state      <= STUCK;
              duty_out   <= 7'd0;
              period_out <= 8'd255;
              stuck_hi   <= 1'b0;
              stuck_lo   <= 1'b1;
              valid      <= 1'b1;
            end
          end
        end
        STUCK: begin
          if (rise) begin
            state    <= HIGH;
            stuck_hi <= 1'b0;
            stuck_lo <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture with DVSR_FAST=3 (1 tick per 4 clk) and DVSR_SLOW=1.
// Expected values are hand-derived: duty = floor(high_clk/4), period = floor(period_clk/4), saturated.
module tb_pwm_capture;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pwm_in = 1'b0;
  logic       sel = 1'b0;
  logic [6:0] duty_out;
  logic [7:0] period_out;
  logic       valid, stuck_hi, stuck_lo;

  pwm_capture #(.DVSR_FAST(3), .DVSR_SLOW(1), .PRESC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in), .sel(sel),
    .duty_out(duty_out), .period_out(period_out), .valid(valid),
    .stuck_hi(stuck_hi), .stuck_lo(stuck_lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    int hi_clk;
    int lo_clk;
    int exp_duty;
    int exp_period;
  } vec_t;

  vec_t vecs[7];
  int   n_vec = 0;
  int   n_bad = 0;

  // Valid-strobe log, written only by the monitor.
  logic [6:0] log_duty[256];
  logic [7:0] log_period[256];
  logic       log_shi[256];
  logic       log_slo[256];
  int         vtotal = 0;
  int         long_pulses = 0;
  logic       valid_prev = 1'b0;
  int         rd_idx = 0;

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (vtotal < 256) begin
        log_duty[vtotal]   = duty_out;
        log_period[vtotal] = period_out;
        log_shi[vtotal]    = stuck_hi;
        log_slo[vtotal]    = stuck_lo;
      end
      vtotal = vtotal + 1;
      if (valid_prev) long_pulses = long_pulses + 1;
    end
    valid_prev = (valid === 1'b1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_next(input string name, input int d, input int p, input int sh, input int sl);
    check({name, "_valid_seen"}, 32'(vtotal > rd_idx), 32'd1);
    if (vtotal > rd_idx && rd_idx < 256) begin
      check({name, "_duty"},     32'(log_duty[rd_idx]),   32'(d));
      check({name, "_period"},   32'(log_period[rd_idx]), 32'(p));
      check({name, "_stuck_hi"}, 32'(log_shi[rd_idx]),    32'(sh));
      check({name, "_stuck_lo"}, 32'(log_slo[rd_idx]),    32'(sl));
      rd_idx++;
    end
  endtask

  task automatic check_none(input string name);
    check({name, "_extra_valids"}, 32'(vtotal - rd_idx), 32'd0);
    rd_idx = vtotal;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply(input int hi, input int lo);
    pwm_in = 1'b1;
    wait_clk(hi);
    pwm_in = 1'b0;
    wait_clk(lo);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_duty"},     32'(duty_out),   32'd0);
    check({name, "_period"},   32'(period_out), 32'd0);
    check({name, "_valid"},    32'(valid),      32'd0);
    check({name, "_stuck_hi"}, 32'(stuck_hi),   32'd0);
    check({name, "_stuck_lo"}, 32'(stuck_lo),   32'd0);
  endtask

  initial begin
    logic found;
    logic [31:0] qmax;

    vecs[0] = '{40,  88,  10,  32};
    vecs[1] = '{40,  88,  10,  32};
    vecs[2] = '{20,  44,   5,  16};
    vecs[3] = '{10,  30,   2,  10};
    vecs[4] = '{600, 40,  127, 160};
    vecs[5] = '{200, 900, 50,  255};
    vecs[6] = '{40,  88,  10,  32};

    // Reset held: all outputs zero.
    wait_clk(4);
    check_outputs_zero("reset");
    rst_n = 1'b0;
    wait_clk(4);

    // Table: the valid for vector i-1 arrives on the rise that starts vector i.
    for (int i = 0; i < 7; i++) begin
      apply(vecs[i].hi_clk, vecs[i].lo_clk);
      if (i == 0) check_none("first_rise");
      else check_next($sformatf("vec%0d", i - 1), vecs[i-1].exp_duty, vecs[i-1].exp_period, 0, 0);
    end
    pwm_in = 1'b1;
    wait_clk(12);
    check_next("vec6", vecs[6].exp_duty, vecs[6].exp_period, 0, 0);

    // Stuck high: 255 ticks after the rise, then falls are ignored until the next rise.
    wait_clk(1100);
    check_next("stuck_hi_event", 127, 255, 1, 0);
    check("stuck_hi_level", 32'(stuck_hi), 32'd1);
    pwm_in = 1'b0;
    wait_clk(40);
    check("stuck_hi_holds", 32'(stuck_hi), 32'd1);
    pwm_in = 1'b1;
    wait_clk(12);
    check("stuck_hi_cleared", 32'(stuck_hi), 32'd0);
    check_none("stuck_hi_exit");

    // Stuck low after a fall.
    wait_clk(28);
    pwm_in = 1'b0;
    wait_clk(1100);
    check_next("stuck_lo_event", 0, 255, 0, 1);
    check("stuck_lo_level", 32'(stuck_lo), 32'd1);
    pwm_in = 1'b1;
    wait_clk(12);
    check("stuck_lo_cleared", 32'(stuck_lo), 32'd0);
    check_none("stuck_lo_exit");
    wait_clk(28);
    pwm_in = 1'b0;
    wait_clk(88);

    // 2-clk low glitch inside a 40-clk high phase.
    pwm_in = 1'b1;
    wait_clk(16);
    pwm_in = 1'b0;
    wait_clk(2);
    pwm_in = 1'b1;
    wait_clk(22);
    pwm_in = 1'b0;
    wait_clk(88);
    pwm_in = 1'b1;
    wait_clk(12);
    check_next("pre_glitch", 10, 32, 0, 0);
`ifdef GLITCH_FILTER_EN
    check_next("glitch_filtered", 10, 32, 0, 0);
`else
    check_next("glitch_split_a", 4, 4, 0, 0);
    check_next("glitch_split_b", 5, 27, 0, 0);
`endif
    check_none("glitch_done");

    // Divisor switch mid-LOW with q above the new terminal count.
    wait_clk(28);
    pwm_in = 1'b0;
    wait_clk(20);
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      if (dut.q == 32'd2) found = 1'b1;
      else @(negedge clk);
    end
    check("q_reaches_2", 32'(found), 32'd1);
    if (found) begin
      sel = 1'b1;
      @(negedge clk);
      check("q_wraps_on_sel", dut.q, 32'd0);
      qmax = 32'd0;
      repeat (6) begin
        @(negedge clk);
        if (dut.q > qmax) qmax = dut.q;
      end
      check("q_bounded_slow", qmax, 32'd1);
    end

    // Reset mid-stream, then the first rise only starts a measurement.
    rst_n = 1'b1;
    sel   = 1'b0;
    wait_clk(3);
    check_outputs_zero("mid_reset");
    rst_n = 1'b0;
    rd_idx = vtotal;
    wait_clk(4);
    apply(40, 88);
    check_none("post_reset_first_rise");
    apply(40, 88);
    check_next("post_reset_second_rise", 10, 32, 0, 0);

    check("valid_one_cycle", 32'(long_pulses), 32'd0);
    check_none("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
